// File: rtl/rd_wb_stage.sv
// Registered writeback stage: picks imm / link / ALU / formatted load data and
// waits for late memory responses. Optional watchdog: define RD_WB_TIMEOUT_EN.
module rd_wb_stage #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_W     = 5,
  parameter int PC_LINK_OFFSET = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 rd_sel,
  input  logic [XLEN-1:0]            imm,
  input  logic [XLEN-1:0]            pc,
  input  logic [XLEN-1:0]            alu_out,
  input  logic [XLEN-1:0]            rd_mem,
  input  logic                       mem_valid,
  input  logic [1:0]                 ld_size,
  input  logic                       ld_unsigned,
  input  logic [$clog2(XLEN/8)-1:0]  ld_off,
  input  logic [REG_ADDR_W-1:0]      rd_addr_in,
  input  logic                       rd_we_in,
  output logic [XLEN-1:0]            rd_d,
  output logic [REG_ADDR_W-1:0]      rd_addr,
  output logic                       rd_we,
  output logic                       out_valid,
  output logic                       mem_timeout,
  output logic                       state_dbg
);

  localparam int OFF_W = $clog2(XLEN/8);

  // Handshake: a request transfers on a rising edge where in_valid & in_ready;
  // in_ready depends only on state, never on in_valid.
  typedef enum logic {IDLE = 1'b0, WAIT_MEM = 1'b1} state_t;
  state_t state;

  logic [1:0]            cap_size;
  logic                  cap_uns;
  logic [OFF_W-1:0]      cap_off;
  logic [REG_ADDR_W-1:0] cap_addr;
  logic                  cap_we;
  logic [XLEN-1:0]       src_data;

`ifdef RD_WB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
  assign mem_timeout    = 1'b0;
`endif

  // Lane offset is aligned down to the access size before shifting.
  function automatic logic [XLEN-1:0] fmt_load(input logic [XLEN-1:0]  raw,
                                               input logic [1:0]       size,
                                               input logic             uns,
                                               input logic [OFF_W-1:0] off);
    logic [OFF_W-1:0] lane_off;
    logic [XLEN-1:0]  sh;
    logic [XLEN-1:0]  res;
    lane_off = off;
    if (size == 2'd1)      lane_off = off & ~OFF_W'(1);
    else if (size == 2'd2) lane_off = off & ~OFF_W'(3);
    sh  = raw >> {lane_off, 3'b000};
    res = raw;
    case (size)
      2'd0: if (uns) res = XLEN'(sh[7:0]);  else res = XLEN'($signed(sh[7:0]));
      2'd1: if (uns) res = XLEN'(sh[15:0]); else res = XLEN'($signed(sh[15:0]));
      2'd2: if (uns) res = XLEN'(sh[31:0]); else res = XLEN'($signed(sh[31:0]));
      default: res = raw;
    endcase
    return res;
  endfunction

  always_comb begin
    src_data = imm;
    case (rd_sel)
      2'd0:    src_data = imm;
      2'd1:    src_data = pc + XLEN'(PC_LINK_OFFSET);
      2'd2:    src_data = alu_out;
      default: src_data = fmt_load(rd_mem, ld_size, ld_unsigned, ld_off);
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign state_dbg = (state == WAIT_MEM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_d      <= '0;
      rd_addr   <= '0;
      rd_we     <= 1'b0;
      out_valid <= 1'b0;
      cap_size  <= '0;
      cap_uns   <= 1'b0;
      cap_off   <= '0;
      cap_addr  <= '0;
      cap_we    <= 1'b0;
`ifdef RD_WB_TIMEOUT_EN
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (rd_sel == 2'd3 && !mem_valid) begin
              cap_size <= ld_size;
              cap_uns  <= ld_unsigned;
              cap_off  <= ld_off;
              cap_addr <= rd_addr_in;
              cap_we   <= rd_we_in && (rd_addr_in != '0);
              state    <= WAIT_MEM;
`ifdef RD_WB_TIMEOUT_EN
              wait_cnt <= '0;
`endif
            end else begin
              rd_d      <= src_data;
              rd_addr   <= rd_addr_in;
              rd_we     <= rd_we_in && (rd_addr_in != '0);
              out_valid <= 1'b1;
            end
          end
        end
        WAIT_MEM: begin
          if (mem_valid) begin
            rd_d      <= fmt_load(rd_mem, cap_size, cap_uns, cap_off);
            rd_addr   <= cap_addr;
            rd_we     <= cap_we;
            out_valid <= 1'b1;
            state     <= IDLE;
          end
`ifdef RD_WB_TIMEOUT_EN
          // A response on the limit edge wins over the watchdog.
          else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            mem_timeout <= 1'b1;
            rd_d        <= '0;
            rd_addr     <= cap_addr;
            rd_we       <= 1'b0;
            out_valid   <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rd_wb_stage.sv
// Directed bench for rd_wb_stage (XLEN=32): per-cycle compare against a
// writeback model plus literal expectations for the documented examples.
module tb_rd_wb_stage;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int W    = XLEN + AW + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [1:0]      rd_sel = '0;
  logic [XLEN-1:0] imm = '0, pc = '0, alu_out = '0, rd_mem = '0;
  logic            mem_valid = 1'b0;
  logic [1:0]      ld_size = '0;
  logic            ld_unsigned = 1'b0;
  logic [1:0]      ld_off = '0;
  logic [AW-1:0]   rd_addr_in = '0;
  logic            rd_we_in = 1'b0;
  logic [XLEN-1:0] rd_d;
  logic [AW-1:0]   rd_addr;
  logic            rd_we;
  logic            out_valid;
  logic            mem_timeout;
  logic            state_dbg;

  rd_wb_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rd_sel(rd_sel), .imm(imm), .pc(pc), .alu_out(alu_out), .rd_mem(rd_mem),
    .mem_valid(mem_valid), .ld_size(ld_size), .ld_unsigned(ld_unsigned),
    .ld_off(ld_off), .rd_addr_in(rd_addr_in), .rd_we_in(rd_we_in),
    .rd_d(rd_d), .rd_addr(rd_addr), .rd_we(rd_we), .out_valid(out_valid),
    .mem_timeout(mem_timeout), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- model state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_wb = '0;
  bit           waiting = 1'b0;
  logic [1:0]   cap_size;
  logic         cap_uns;
  logic [1:0]   cap_off;
  logic [AW-1:0] cap_addr;
  logic         cap_we;
  int           checks = 0;
  int           failures = 0;

  task automatic fail(input string name, input logic [63:0] act, input logic [63:0] exp);
    failures++;
    $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
  endtask

  task automatic check_lit(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) fail(name, act, exp);
  endtask

  // Load lane by byte arithmetic: aligned start, mask, then sign fill.
  function automatic logic [31:0] model_load(input logic [31:0] raw, input logic [1:0] size,
                                             input logic uns, input logic [1:0] off);
    int          nb;
    int          start;
    longint      lane;
    longint      mask;
    nb    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    start = (int'(off) / nb) * nb;
    mask  = (64'd1 << (8 * nb)) - 1;
    lane  = (longint'(raw) >> (8 * start)) & mask;
    if (size != 2'd3 && !uns && lane[8*nb-1]) lane = lane | ~mask;
    return lane[31:0];
  endfunction

  function automatic logic [31:0] model_wb(input logic [1:0] sel, input logic [31:0] val,
                                           input logic [1:0] size, input logic uns,
                                           input logic [1:0] off);
    logic [31:0] r;
    case (sel)
      2'd1:    r = val + 32'd4;
      2'd3:    r = model_load(val, size, uns, off);
      default: r = val;
    endcase
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [1:0] sel, input logic [31:0] val, input logic mv,
                       input logic [1:0] size, input logic uns, input logic [1:0] off,
                       input logic [AW-1:0] addr, input logic we);
    in_valid = 1'b1; rd_sel = sel;
    imm = $urandom; pc = $urandom; alu_out = $urandom; rd_mem = $urandom;
    case (sel)
      2'd0: imm = val;
      2'd1: pc = val;
      2'd2: alu_out = val;
      default: rd_mem = val;
    endcase
    mem_valid = mv; ld_size = size; ld_unsigned = uns; ld_off = off;
    rd_addr_in = addr; rd_we_in = we;
    @(posedge clk);
    if (sel != 2'd3 || mv) begin
      exp_q.push_back({model_wb(sel, val, size, uns, off), addr, we && (addr != '0)});
    end else begin
      waiting = 1'b1;
      cap_size = size; cap_uns = uns; cap_off = off; cap_addr = addr; cap_we = we;
    end
    #1;
    in_valid = 1'b0; mem_valid = 1'b0;
  endtask

  // Idle cycles in WAIT_MEM with junk on the ignored inputs, then the response.
  task automatic late_resp(input int n_wait, input logic [31:0] raw);
    repeat (n_wait) begin
      in_valid = 1'b1; rd_sel = 2'($urandom_range(0, 3)); imm = $urandom;
      ld_size = 2'($urandom_range(0, 3)); ld_off = 2'($urandom_range(0, 3));
      rd_addr_in = 5'($urandom_range(0, 31)); rd_we_in = 1'b1; mem_valid = 1'b0;
      @(posedge clk); #1;
    end
    mem_valid = 1'b1; rd_mem = raw;
    @(posedge clk);
    exp_q.push_back({model_load(raw, cap_size, cap_uns, cap_off), cap_addr, cap_we});
    waiting = 1'b0;
    #1;
    mem_valid = 1'b0; in_valid = 1'b0;
  endtask

  task automatic expect_rd(input string name, input logic [31:0] exp);
    @(negedge clk);
    check_lit(name, rd_d, exp);
  endtask

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    checks++;
    if (out_valid !== (exp_q.size() != 0)) fail("out_valid", out_valid, exp_q.size() != 0);
    checks++;
    if (in_ready !== !waiting) fail("in_ready", in_ready, !waiting);
    checks++;
    if (state_dbg !== waiting) fail("state_dbg", state_dbg, waiting);
    checks++;
    if (mem_timeout !== 1'b0) fail("mem_timeout", mem_timeout, 0);
    if (exp_q.size() != 0) last_wb = exp_q.pop_front();
    checks++;
    if ({rd_d, rd_addr, rd_we} !== last_wb) fail("wb_regs", {rd_d, rd_addr, rd_we}, last_wb);
  end

  // ---------------- stimulus ----------------
  logic [31:0] ld_word = 32'h80F0_7F10;

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check_lit("reset_rd_d", rd_d, 0);
    check_lit("reset_out_valid", out_valid, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    check_lit("reset_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // back-to-back imm then ALU
    issue(2'd0, 32'd10, 1'b0, 2'd0, 1'b0, 2'd0, 5'd1, 1'b1);
    expect_rd("b2b_imm", 32'd10);
    issue(2'd2, 32'hFFFF_FFFC, 1'b0, 2'd0, 1'b0, 2'd0, 5'd2, 1'b1);
    expect_rd("b2b_alu", 32'hFFFF_FFFC);

    // link with wrap
    issue(2'd1, 32'hFFFF_FFFC, 1'b0, 2'd0, 1'b0, 2'd0, 5'd3, 1'b1);
    expect_rd("link_wrap", 32'h0000_0000);
    issue(2'd1, 32'h0000_0100, 1'b0, 2'd0, 1'b0, 2'd0, 5'd3, 1'b1);
    expect_rd("link_104", 32'h0000_0104);

    // load formatting, response present at accept
    issue(2'd3, ld_word, 1'b1, 2'd0, 1'b0, 2'd1, 5'd4, 1'b1);
    expect_rd("ld_b_off1_s", 32'h0000_007F);
    issue(2'd3, ld_word, 1'b1, 2'd0, 1'b0, 2'd3, 5'd4, 1'b1);
    expect_rd("ld_b_off3_s", 32'hFFFF_FF80);
    issue(2'd3, ld_word, 1'b1, 2'd1, 1'b1, 2'd2, 5'd5, 1'b1);
    expect_rd("ld_h_off2_u", 32'h0000_80F0);
    issue(2'd3, ld_word, 1'b1, 2'd2, 1'b0, 2'd0, 5'd6, 1'b1);
    expect_rd("ld_w", 32'h80F0_7F10);
    issue(2'd3, ld_word, 1'b1, 2'd1, 1'b0, 2'd3, 5'd6, 1'b1);
    expect_rd("ld_h_off3_s", 32'hFFFF_80F0);
    issue(2'd3, ld_word, 1'b1, 2'd3, 1'b1, 2'd2, 5'd7, 1'b1);
    expect_rd("ld_full", 32'h80F0_7F10);

    // sweep every size/sign/offset back-to-back; the model checks each
    for (int s = 0; s < 4; s++)
      for (int u = 0; u < 2; u++)
        for (int o = 0; o < 4; o++)
          issue(2'd3, 32'h8899_AA3B, 1'b1, 2'(s), 1'(u), 2'(o), 5'(o + 8), 1'b1);

    // late response, three cycles after accept
    issue(2'd3, 32'h1234_5678, 1'b0, 2'd1, 1'b0, 2'd0, 5'd9, 1'b1);
    check_lit("late_in_ready_low", in_ready, 0);
    late_resp(2, 32'h0000_FFF0);
    expect_rd("late_half_s", 32'hFFFF_FFF0);
    check_lit("late_in_ready_back", in_ready, 1);

    // x0 destination never writes
    issue(2'd0, 32'hCAFE_F00D, 1'b0, 2'd0, 1'b0, 2'd0, 5'd0, 1'b1);
    @(negedge clk);
    check_lit("x0_rd_we", rd_we, 0);
    check_lit("x0_rd_d", rd_d, 32'hCAFE_F00D);
    issue(2'd2, 32'h0000_0055, 1'b0, 2'd0, 1'b0, 2'd0, 5'd31, 1'b0);
    @(negedge clk);
    check_lit("we_in_low", rd_we, 0);

    // reset abandons a pending load
    issue(2'd3, 32'h0, 1'b0, 2'd0, 1'b1, 2'd0, 5'd12, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete(); waiting = 1'b0; last_wb = '0;
    #2;
    check_lit("rst_mid_rd_d", rd_d, 0);
    check_lit("rst_mid_rd_we", rd_we, 0);
    check_lit("rst_mid_rd_addr", rd_addr, 0);
    @(posedge clk); #1 mem_valid = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1; mem_valid = 1'b0;
    check_lit("rst_mid_in_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    check_lit("rst_no_out_valid", out_valid, 0);

    // stage works again after the abandoned load
    issue(2'd3, 32'h0000_00A5, 1'b0, 2'd0, 1'b1, 2'd0, 5'd13, 1'b1);
    late_resp(0, 32'h0000_00A5);
    expect_rd("post_rst_load", 32'h0000_00A5);

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      checks++;
      fail("pending_writebacks", exp_q.size(), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

endmodule
